// File: rtl/mmc_resp_send.sv
// rtl/mmc_resp_send.sv - MMC/SD CMD-line response transmitter (48-bit with CRC7, 136-bit R2)
//
// Drives response packets onto the shared CMD wire from the clk domain.
// mmc_clk is oversampled and every line change is made on the clk edge
// where its synchronized falling edge is detected. This gives the host a
// stable bit at the following rising edge.
//
// Ports:
//   clk, reset_i      system clock, synchronous active-high reset
//   mmc_clk           bus clock (asynchronous, period >= 4 clk)
//   tx_start          single-cycle request, accepted only when idle
//   tx_long           0 = 48-bit short packet, 1 = 136-bit R2 packet
//   tx_index, tx_arg  short packet index and argument
//   tx_long_data      R2 payload bits [127:1], sent verbatim
//   mmc_cmd_out/oe    CMD line data and drive enable
//   tx_busy, tx_done  busy level and one-cycle completion pulse
//   debug_state/cnt   FSM state encoding and bit/wait counter

module mmc_resp_send #(
   parameter int   NCR_CYCLES = 2,
   parameter logic TRANS_BIT  = 1'b0
) (
   input  logic         clk,
   input  logic         reset_i,
   input  logic         mmc_clk,
   input  logic         tx_start,
   input  logic         tx_long,
   input  logic [5:0]   tx_index,
   input  logic [31:0]  tx_arg,
   input  logic [126:0] tx_long_data,
   output logic         mmc_cmd_out,
   output logic         mmc_cmd_oe,
   output logic         tx_busy,
   output logic         tx_done,
   output logic [2:0]   debug_state,
   output logic [8:0]   debug_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_WAIT  = 3'b001,
      S_SHIFT = 3'b010,
      S_HOLD  = 3'b011
   } state_t;

   localparam logic [8:0] LP_NCR       = 9'(NCR_CYCLES);
   localparam logic [8:0] LP_LAST_LONG = 9'd135;
   localparam logic [8:0] LP_LAST_SHORT = 9'd47;
   // Short packets: while the count is above this value the payload is sent,
   // then 7 CRC bits follow, then the end bit.
   localparam logic [8:0] LP_CRC_FIRST = 9'd8;

   state_t         r_state;
   logic           r_sync1;
   logic           r_sync2;
   logic           r_hist;
   logic [8:0]     r_cnt;
   logic [134:0]   r_shift;
   logic [6:0]     r_crc;
   logic           r_long;
   logic           r_out;
   logic           r_oe;
   logic           r_busy;
   logic           r_done;

   logic           w_fe;
   logic           w_fb;
   logic [6:0]     w_crc_next;

   assign w_fe       = r_hist & ~r_sync2;
   // Serial CRC7 (x^7 + x^3 + 1) folded with the bit about to be driven.
   assign w_fb       = r_shift[134] ^ r_crc[6];
   assign w_crc_next = {r_crc[5:0], 1'b0} ^ {3'b000, w_fb, 2'b00, w_fb};

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_state <= S_IDLE;
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_hist  <= 1'b0;
         r_cnt   <= '0;
         r_shift <= '0;
         r_crc   <= '0;
         r_long  <= 1'b0;
         r_out   <= 1'b1;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_sync1 <= mmc_clk;
         r_sync2 <= r_sync1;
         r_hist  <= r_sync2;
         r_done  <= 1'b0;

         case (r_state)
            S_IDLE: begin
               r_oe   <= 1'b0;
               r_out  <= 1'b1;
               r_busy <= 1'b0;
               // A falling edge coinciding with acceptance is deliberately
               // not counted: counting starts in WAIT.
               if (tx_start) begin
                  r_long  <= tx_long;
                  r_shift <= tx_long ? {TRANS_BIT, 6'h3F, tx_long_data, 1'b1}
                                     : {TRANS_BIT, tx_index, tx_arg, 96'd0};
                  // The start bit is 0, which leaves a zero CRC unchanged,
                  // so the CRC needs no update when the start bit is driven.
                  r_crc   <= '0;
                  r_cnt   <= LP_NCR;
                  r_busy  <= 1'b1;
                  r_state <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (w_fe) begin
                  if (r_cnt <= 9'd1) begin
                     r_oe    <= 1'b1;
                     r_out   <= 1'b0;
                     r_cnt   <= r_long ? LP_LAST_LONG : LP_LAST_SHORT;
                     r_state <= S_SHIFT;
                  end else begin
                     r_cnt <= r_cnt - 9'd1;
                  end
               end
            end

            S_SHIFT: begin
               if (w_fe) begin
                  r_cnt <= r_cnt - 9'd1;
                  if (r_long || (r_cnt > LP_CRC_FIRST)) begin
                     r_out   <= r_shift[134];
                     r_shift <= {r_shift[133:0], 1'b0};
                     if (!r_long) begin
                        r_crc <= w_crc_next;
                     end
                  end else if (r_cnt > 9'd1) begin
                     r_out <= r_crc[6];
                     r_crc <= {r_crc[5:0], 1'b0};
                  end else begin
                     r_out <= 1'b1;
                  end
                  if (r_cnt == 9'd1) begin
                     r_state <= S_HOLD;
                  end
               end
            end

            S_HOLD: begin
               if (w_fe) begin
                  r_oe    <= 1'b0;
                  r_out   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_oe    <= 1'b0;
               r_out   <= 1'b1;
               r_busy  <= 1'b0;
               r_cnt   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign mmc_cmd_out = r_out;
   assign mmc_cmd_oe  = r_oe;
   assign tx_busy     = r_busy;
   assign tx_done     = r_done;
   assign debug_state = r_state;
   assign debug_cnt   = r_cnt;

endmodule

// File: tb/tb_mmc_resp_send.sv
// tb/tb_mmc_resp_send.sv - randomized self-checking bench for mmc_resp_send

module tb_mmc_resp_send;

   logic         clk = 1'b0;
   logic         reset_i = 1'b1;
   logic         mmc_clk = 1'b1;
   logic         mmc_run = 1'b0;
   logic         tx_start = 1'b0;
   logic         tx_long = 1'b0;
   logic [5:0]   tx_index = '0;
   logic [31:0]  tx_arg = '0;
   logic [126:0] tx_long_data = '0;

   logic         out0, oe0, busy0, done0;
   logic         out1, oe1, busy1, done1;
   logic [2:0]   st0, st1;
   logic [8:0]   cnt0, cnt1;

   int n_vec = 0;
   int n_bad = 0;
   int fe_total = 0;
   logic q0[$];
   logic q1[$];

   mmc_resp_send #(.NCR_CYCLES(2), .TRANS_BIT(1'b0)) dut0 (
      .clk(clk), .reset_i(reset_i), .mmc_clk(mmc_clk), .tx_start(tx_start),
      .tx_long(tx_long), .tx_index(tx_index), .tx_arg(tx_arg),
      .tx_long_data(tx_long_data), .mmc_cmd_out(out0), .mmc_cmd_oe(oe0),
      .tx_busy(busy0), .tx_done(done0), .debug_state(st0), .debug_cnt(cnt0));

   mmc_resp_send #(.NCR_CYCLES(2), .TRANS_BIT(1'b1)) dut1 (
      .clk(clk), .reset_i(reset_i), .mmc_clk(mmc_clk), .tx_start(tx_start),
      .tx_long(tx_long), .tx_index(tx_index), .tx_arg(tx_arg),
      .tx_long_data(tx_long_data), .mmc_cmd_out(out1), .mmc_cmd_oe(oe1),
      .tx_busy(busy1), .tx_done(done1), .debug_state(st1), .debug_cnt(cnt1));

   always #5 clk = ~clk;

   // mmc_clk: 100 ns period (10 clk), offset so its edges never meet clk edges.
   initial begin
      #3;
      forever begin
         #50;
         if (mmc_run) mmc_clk = ~mmc_clk;
      end
   end

   // Host-side capture on the rising edge, as the real host samples.
   always @(posedge mmc_clk) begin
      if (oe0) q0.push_back(out0);
      if (oe1) q1.push_back(out1);
   end

   always @(negedge mmc_clk) fe_total++;

   function automatic logic [6:0] crc7(input logic [39:0] m);
      logic [46:0] v;
      v = {m, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (v[i]) v = v ^ (47'h89 << (i - 7));
      return v[6:0];
   endfunction

   function automatic logic [135:0] model_pkt(input logic lng, input logic tbit,
         input logic [5:0] idx, input logic [31:0] arg, input logic [126:0] d);
      logic [39:0] m;
      if (lng) return {1'b0, tbit, 6'h3F, d, 1'b1};
      m = {1'b0, tbit, idx, arg};
      return {88'd0, m, crc7(m), 1'b1};
   endfunction

   task automatic send(input string name, input logic lng, input logic [5:0] idx,
         input logic [31:0] arg, input logic [126:0] d, input bit poke, input bit chain,
         output logic [7:0] last0, output logic [7:0] last1);
      int b0, b1, fe_base, first_oe, n0, n1, len, ndone;
      bit seen;
      logic [135:0] g0, g1, e0, e1;
      b0 = q0.size();
      b1 = q1.size();
      if (!chain) begin
         @(posedge mmc_clk);
         @(negedge clk);
      end
      fe_base = fe_total;
      tx_long = lng; tx_index = idx; tx_arg = arg; tx_long_data = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      n_vec++;
      if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
         n_bad++;
         $display("FAIL %s busy_after_start got %b/%b want 1/1", name, busy0, busy1);
      end
      first_oe = -1; seen = 0; ndone = 0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk);
         if (first_oe < 0 && oe0 === 1'b1) first_oe = fe_total - fe_base;
         if (poke && i == 300) begin
            tx_start = 1'b1; tx_index = idx ^ 6'h15; tx_arg = ~arg; tx_long = ~lng;
         end else begin
            tx_start = 1'b0;
         end
         if (done0 === 1'b1) begin
            seen = 1;
            ndone++;
         end
      end
      n_vec++;
      if (!seen) begin
         n_bad++;
         $display("FAIL %s done_timeout got no tx_done want one", name);
      end
      if (!chain) begin
         n_vec++;
         if (first_oe != 2) begin
            n_bad++;
            $display("FAIL %s ncr_delay got %0d fe want 2", name, first_oe);
         end
      end
      n_vec++;
      if (oe0 !== 1'b0 || busy0 !== 1'b0 || done1 !== 1'b1 || oe1 !== 1'b0) begin
         n_bad++;
         $display("FAIL %s done_cycle got oe=%b busy=%b done1=%b oe1=%b want 0 0 1 0",
                  name, oe0, busy0, done1, oe1);
      end
      len = lng ? 136 : 48;
      n0 = q0.size() - b0;
      n1 = q1.size() - b1;
      n_vec++;
      if (n0 != len || n1 != len) begin
         n_bad++;
         $display("FAIL %s driven_bits got %0d/%0d want %0d", name, n0, n1, len);
      end
      g0 = '0; g1 = '0;
      for (int k = 0; k < n0 && k < 136; k++) g0 = {g0[134:0], q0[b0 + k]};
      for (int k = 0; k < n1 && k < 136; k++) g1 = {g1[134:0], q1[b1 + k]};
      e0 = model_pkt(lng, 1'b0, idx, arg, d);
      e1 = model_pkt(lng, 1'b1, idx, arg, d);
      n_vec++;
      if (g0 !== e0) begin
         n_bad++;
         $display("FAIL %s packet_t0 got %h want %h", name, g0, e0);
      end
      n_vec++;
      if (g1 !== e1) begin
         n_bad++;
         $display("FAIL %s packet_t1 got %h want %h", name, g1, e1);
      end
      last0 = g0[7:0];
      last1 = g1[7:0];
   endtask

   task automatic test_reset();
      int bad;
      reset_i = 1'b1;
      mmc_run = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++;
      if (out0 !== 1'b1 || oe0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
          st0 !== 3'b000 || cnt0 !== 9'd0 || oe1 !== 1'b0 || out1 !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_values got out=%b oe=%b busy=%b done=%b st=%b cnt=%0d want 1 0 0 0 000 0",
                  out0, oe0, busy0, done0, st0, cnt0);
      end
      reset_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 120; i++) begin
         @(negedge clk);
         if (oe0 !== 1'b0 || out0 !== 1'b1 || busy0 !== 1'b0 || st0 !== 3'b000 ||
             oe1 !== 1'b0 || busy1 !== 1'b0) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL idle_toggle got %0d bad samples want 0", bad);
      end
   endtask

   task automatic test_zero_short();
      logic [7:0] l0, l1;
      send("zero_short", 1'b0, 6'd0, 32'd0, '0, 0, 0, l0, l1);
      n_vec++;
      if (l0 !== 8'h01) begin
         n_bad++;
         $display("FAIL zero_last_byte got %h want 01", l0);
      end
   endtask

   task automatic test_crc_vectors();
      logic [7:0] l0, l1;
      logic [5:0] idx[3] = '{6'd0, 6'd8, 6'd17};
      logic [31:0] arg[3] = '{32'd0, 32'h000001AA, 32'd0};
      logic [7:0] want[3] = '{8'h95, 8'h87, 8'h55};
      for (int i = 0; i < 3; i++) begin
         send("crc_vec", 1'b0, idx[i], arg[i], '0, 0, 0, l0, l1);
         n_vec++;
         if (l1 !== want[i]) begin
            n_bad++;
            $display("FAIL crc_vec%0d last_byte got %h want %h", i, l1, want[i]);
         end
      end
   endtask

   task automatic test_random_short();
      logic [7:0] l0, l1;
      for (int i = 0; i < 4; i++)
         send("rand_short", 1'b0, 6'($urandom), $urandom, '0, 0, 0, l0, l1);
   endtask

   task automatic test_long();
      logic [7:0] l0, l1;
      logic [126:0] d;
      for (int i = 0; i < 2; i++) begin
         d = {31'($urandom), $urandom, $urandom, $urandom};
         send("long", 1'b1, 6'($urandom), $urandom, d, 0, 0, l0, l1);
      end
   endtask

   task automatic test_busy_ignore();
      logic [7:0] l0, l1;
      int extra;
      send("busy_ignore", 1'b0, 6'd33, 32'hDEADBEEF, '0, 1, 0, l0, l1);
      extra = 0;
      for (int i = 0; i < 700; i++) begin
         @(negedge clk);
         if (done0 === 1'b1 || oe0 === 1'b1) extra++;
      end
      n_vec++;
      if (extra != 0) begin
         n_bad++;
         $display("FAIL busy_ignore extra_activity got %0d cycles want 0", extra);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] l0, l1;
      send("b2b_first", 1'b0, 6'd5, $urandom, '0, 0, 0, l0, l1);
      send("b2b_second", 1'b0, 6'd6, $urandom, '0, 0, 1, l0, l1);
   endtask

   task automatic test_reset_mid();
      logic [7:0] l0, l1;
      int b0, guard, bad;
      b0 = q0.size();
      @(posedge mmc_clk);
      @(negedge clk);
      tx_long = 1'b1; tx_long_data = {31'($urandom), $urandom, $urandom, $urandom};
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      guard = 0;
      while (q0.size() - b0 < 21 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      n_vec++;
      if (guard >= 3000) begin
         n_bad++;
         $display("FAIL reset_mid reach_bit20 got %0d bits want 21", q0.size() - b0);
      end
      reset_i = 1'b1;
      @(negedge clk);
      n_vec++;
      if (oe0 !== 1'b0 || out0 !== 1'b1 || st0 !== 3'b000 || busy0 !== 1'b0 ||
          oe1 !== 1'b0 || done0 !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_mid outputs got oe=%b out=%b st=%b busy=%b want 0 1 000 0",
                  oe0, out0, st0, busy0);
      end
      reset_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done0 === 1'b1 || done1 === 1'b1 || oe0 === 1'b1) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         n_bad++;
         $display("FAIL reset_mid no_done got %0d active cycles want 0", bad);
      end
      send("after_reset", 1'b0, 6'($urandom), $urandom, '0, 0, 0, l0, l1);
   endtask

   initial begin
      test_reset();
      test_zero_short();
      test_crc_vectors();
      test_random_short();
      test_long();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
